// File: rtl/updown_counter_param_if.sv
// Control/status bundle for updown_counter_param: stimulus from master, counter state back from slave.
interface updown_counter_param_if #(
  parameter int WIDTH = 8
);
  logic             load;
  logic [WIDTH-1:0] d;
  logic             up_down;
  logic             cten;
  logic [WIDTH-1:0] max_val;
  logic             clr_flag;
  logic [WIDTH-1:0] q;
  logic             max_min;
  logic             rco;
  logic             tc_pulse;
  logic             tc_flag;

  modport master (
    output load, d, up_down, cten, max_val, clr_flag,
    input  q, max_min, rco, tc_pulse, tc_flag
  );

  modport slave (
    input  load, d, up_down, cten, max_val, clr_flag,
    output q, max_min, rco, tc_pulse, tc_flag
  );
endinterface

// File: rtl/updown_counter_param.sv
// Up/down counter with runtime modulus, load, wrap/saturate limits, cascade carry and
// a sticky terminal-count flag; used for irrigation valve-on and soak timing.
module updown_counter_param #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  updown_counter_param_if.slave bus
);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] load_val;
  logic             term;
  logic             tc_pulse_r;
  logic             tc_flag_r;

  assign load_val = (bus.d > bus.max_val) ? bus.max_val : bus.d;

  // A value above max_val (limit lowered at runtime) snaps back into range.
  always_comb begin
    q_next = q_r;
    term   = 1'b0;
    if (!bus.up_down) begin
      if (q_r < bus.max_val) begin
        q_next = q_r + WIDTH'(1);
      end else begin
        term   = 1'b1;
        q_next = SATURATE ? bus.max_val : '0;
      end
    end else begin
      if (q_r > bus.max_val) begin
        q_next = bus.max_val;
      end else if (q_r != '0) begin
        q_next = q_r - WIDTH'(1);
      end else begin
        term   = 1'b1;
        q_next = SATURATE ? '0 : bus.max_val;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r        <= '0;
      tc_pulse_r <= 1'b0;
      tc_flag_r  <= 1'b0;
    end else if (bus.load) begin
      q_r        <= load_val;
      tc_pulse_r <= 1'b0;
      tc_flag_r  <= 1'b0;
    end else if (!bus.cten) begin
      q_r        <= q_next;
      tc_pulse_r <= term;
      tc_flag_r  <= term | (tc_flag_r & ~bus.clr_flag);
    end else begin
      tc_pulse_r <= 1'b0;
      tc_flag_r  <= tc_flag_r & ~bus.clr_flag;
    end
  end

  // max_min ignores cten so a cascaded stage sees its limit regardless of enable.
  assign bus.q        = q_r;
  assign bus.max_min  = bus.up_down ? (q_r == '0) : (q_r == bus.max_val);
  assign bus.rco      = ~(~bus.cten & bus.max_min);
  assign bus.tc_pulse = tc_pulse_r;
  assign bus.tc_flag  = tc_flag_r;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench for updown_counter_param: wrap, saturate and cascaded instances against a
// reference model, with expected results queued at drive time and popped after each edge.
module tb_updown_counter_param;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  updown_counter_param_if #(.WIDTH(8)) bus_a ();
  updown_counter_param_if #(.WIDTH(8)) bus_s ();
  updown_counter_param_if #(.WIDTH(4)) bus_c0 ();
  updown_counter_param_if #(.WIDTH(4)) bus_c1 ();

  assign bus_c1.cten = bus_c0.rco;

  updown_counter_param #(.WIDTH(8), .SATURATE(1'b0)) u_dut (.clk(clk), .reset(reset), .bus(bus_a));
  updown_counter_param #(.WIDTH(8), .SATURATE(1'b1)) u_sat (.clk(clk), .reset(reset), .bus(bus_s));
  updown_counter_param #(.WIDTH(4), .SATURATE(1'b0)) u_c0  (.clk(clk), .reset(reset), .bus(bus_c0));
  updown_counter_param #(.WIDTH(4), .SATURATE(1'b0)) u_c1  (.clk(clk), .reset(reset), .bus(bus_c1));

  typedef struct {
    int          idx;
    logic [31:0] q;
    logic        p;
    logic        f;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] mq[4];
  logic        mf[4];
  string       nm[4]  = '{"a", "s", "c0", "c1"};
  bit          sat[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns {pulse, flag, q} after one edge.
  function automatic logic [33:0] model_next(input bit s, input logic [31:0] q, input logic flag,
                                             input logic ld, input logic [31:0] dd, input logic ud,
                                             input logic ct, input logic [31:0] mv, input logic cl);
    logic [31:0] nq;
    logic        p;
    logic        f;
    nq = q;
    p  = 1'b0;
    f  = flag;
    if (ld) begin
      nq = (dd > mv) ? mv : dd;
      f  = 1'b0;
    end else if (!ct) begin
      if (!ud) begin
        if (q < mv) nq = q + 1;
        else begin p = 1'b1; nq = s ? mv : 32'd0; end
      end else begin
        if (q > mv)       nq = mv;
        else if (q != 0)  nq = q - 1;
        else begin p = 1'b1; nq = s ? 32'd0 : mv; end
      end
      f = p ? 1'b1 : (cl ? 1'b0 : flag);
    end else begin
      f = cl ? 1'b0 : flag;
    end
    return {p, f, nq};
  endfunction

  function automatic void get_in(input int i, output logic ld, output logic [31:0] dd,
                                 output logic ud, output logic ct, output logic [31:0] mv,
                                 output logic cl);
    case (i)
      0: begin ld = bus_a.load;  dd = 32'(bus_a.d);  ud = bus_a.up_down;  ct = bus_a.cten;
               mv = 32'(bus_a.max_val);  cl = bus_a.clr_flag; end
      1: begin ld = bus_s.load;  dd = 32'(bus_s.d);  ud = bus_s.up_down;  ct = bus_s.cten;
               mv = 32'(bus_s.max_val);  cl = bus_s.clr_flag; end
      2: begin ld = bus_c0.load; dd = 32'(bus_c0.d); ud = bus_c0.up_down; ct = bus_c0.cten;
               mv = 32'(bus_c0.max_val); cl = bus_c0.clr_flag; end
      default: begin ld = bus_c1.load; dd = 32'(bus_c1.d); ud = bus_c1.up_down; ct = 1'b1;
               mv = 32'(bus_c1.max_val); cl = bus_c1.clr_flag; end
    endcase
  endfunction

  // {rco, max_min, tc_pulse, tc_flag, q}
  function automatic logic [35:0] act(input int i);
    case (i)
      0: return {bus_a.rco,  bus_a.max_min,  bus_a.tc_pulse,  bus_a.tc_flag,  32'(bus_a.q)};
      1: return {bus_s.rco,  bus_s.max_min,  bus_s.tc_pulse,  bus_s.tc_flag,  32'(bus_s.q)};
      2: return {bus_c0.rco, bus_c0.max_min, bus_c0.tc_pulse, bus_c0.tc_flag, 32'(bus_c0.q)};
      default: return {bus_c1.rco, bus_c1.max_min, bus_c1.tc_pulse, bus_c1.tc_flag, 32'(bus_c1.q)};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mq[i] = 32'd0;
      mf[i] = 1'b0;
    end
  endtask

  // Check combinational outputs, queue next-state expectations, clock once, drain the queue.
  task automatic step();
    logic [33:0] nx[4];
    logic        ld, ud, ct, cl, mm, rc, c0_rco;
    logic [31:0] dd, mv;
    logic [35:0] a;
    exp_t        e;
    c0_rco = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      get_in(i, ld, dd, ud, ct, mv, cl);
      if (i == 3) ct = c0_rco;
      mm = ud ? (mq[i] == 0) : (mq[i] == mv);
      rc = ~(~ct & mm);
      if (i == 2) c0_rco = rc;
      a = act(i);
      check($sformatf("%s.max_min", nm[i]), 32'(a[34]), 32'(mm));
      check($sformatf("%s.rco", nm[i]), 32'(a[35]), 32'(rc));
      nx[i] = model_next(sat[i], mq[i], mf[i], ld, dd, ud, ct, mv, cl);
      sb.push_back('{i, nx[i][31:0], nx[i][33], nx[i][32]});
    end
    for (int i = 0; i < 4; i++) begin
      mq[i] = nx[i][31:0];
      mf[i] = nx[i][32];
    end
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      a = act(e.idx);
      check($sformatf("%s.q", nm[e.idx]), a[31:0], e.q);
      check($sformatf("%s.tc_pulse", nm[e.idx]), 32'(a[33]), 32'(e.p));
      check($sformatf("%s.tc_flag", nm[e.idx]), 32'(a[32]), 32'(e.f));
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_a.load = 1'b0;  bus_a.d = '0;  bus_a.up_down = 1'b0;  bus_a.cten = 1'b1;
    bus_a.max_val = '0; bus_a.clr_flag = 1'b0;
    bus_s.load = 1'b0;  bus_s.d = '0;  bus_s.up_down = 1'b0;  bus_s.cten = 1'b1;
    bus_s.max_val = '0; bus_s.clr_flag = 1'b0;
    bus_c0.load = 1'b0; bus_c0.d = '0; bus_c0.up_down = 1'b0; bus_c0.cten = 1'b1;
    bus_c0.max_val = '0; bus_c0.clr_flag = 1'b0;
    bus_c1.load = 1'b0; bus_c1.d = '0; bus_c1.up_down = 1'b0;
    bus_c1.max_val = '0; bus_c1.clr_flag = 1'b0;
    model_reset();
    #2;
    check("reset.q", 32'(bus_a.q), 32'd0);
    check("reset.tc_pulse", 32'(bus_a.tc_pulse), 32'd0);
    check("reset.tc_flag", 32'(bus_a.tc_flag), 32'd0);
    check("reset.c0.q", 32'(bus_c0.q), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Mod-10 up count on a, 8-bit cascade of two 4-bit stages alongside.
    bus_a.max_val = 8'd9;   bus_a.cten = 1'b0;
    bus_c0.max_val = 4'd15; bus_c0.cten = 1'b0;
    bus_c1.max_val = 4'd15;
    for (int k = 1; k <= 256; k++) begin
      step();
      if (k == 9) begin
        check("up.q9", 32'(bus_a.q), 32'd9);
        check("up.rco_at_9", 32'(bus_a.rco), 32'd0);
      end
      if (k == 10) begin
        check("up.wrap_q", 32'(bus_a.q), 32'd0);
        check("up.wrap_pulse", 32'(bus_a.tc_pulse), 32'd1);
      end
      if (k == 11) check("up.pulse_one_cycle", 32'(bus_a.tc_pulse), 32'd0);
      if (k == 16) check("casc.stage1_adv", 32'(bus_c1.q), 32'd1);
      if (k == 255) check("casc.255", 32'({bus_c1.q, bus_c0.q}), 32'd255);
      if (k == 256) check("casc.wrap", 32'({bus_c1.q, bus_c0.q}), 32'd0);
    end
    bus_c0.cten = 1'b1;

    // Load 2 and count down through the wrap, then clear the sticky flag.
    bus_a.load = 1'b1; bus_a.d = 8'd2; bus_a.up_down = 1'b1;
    step();
    check("down.load", 32'(bus_a.q), 32'd2);
    bus_a.load = 1'b0;
    step();
    step();
    check("down.zero", 32'(bus_a.q), 32'd0);
    step();
    check("down.wrap_q", 32'(bus_a.q), 32'd9);
    check("down.wrap_flag", 32'(bus_a.tc_flag), 32'd1);
    bus_a.cten = 1'b1; bus_a.clr_flag = 1'b1;
    step();
    check("down.clr_flag", 32'(bus_a.tc_flag), 32'd0);
    bus_a.clr_flag = 1'b0;

    // Saturating instance: hold at the upper limit, then reverse.
    bus_s.max_val = 8'd5; bus_s.load = 1'b1; bus_s.d = 8'd4;
    step();
    bus_s.load = 1'b0; bus_s.cten = 1'b0;
    step();
    check("sat.reach", 32'(bus_s.q), 32'd5);
    check("sat.reach_pulse", 32'(bus_s.tc_pulse), 32'd0);
    step();
    check("sat.hold1_pulse", 32'(bus_s.tc_pulse), 32'd1);
    step();
    check("sat.hold2_q", 32'(bus_s.q), 32'd5);
    check("sat.hold2_pulse", 32'(bus_s.tc_pulse), 32'd1);
    bus_s.up_down = 1'b1;
    step();
    step();
    check("sat.down", 32'(bus_s.q), 32'd3);
    bus_s.cten = 1'b1;

    // Load clamp, then load overriding an enabled count.
    bus_a.max_val = 8'd50; bus_a.up_down = 1'b0; bus_a.load = 1'b1; bus_a.d = 8'd200;
    step();
    check("load.clamp", 32'(bus_a.q), 32'd50);
    bus_a.load = 1'b0; bus_a.cten = 1'b0;
    step();
    check("load.pre_flag", 32'(bus_a.tc_flag), 32'd1);
    bus_a.load = 1'b1; bus_a.d = 8'd7;
    step();
    check("load.over_cten_q", 32'(bus_a.q), 32'd7);
    check("load.over_cten_flag", 32'(bus_a.tc_flag), 32'd0);
    bus_a.load = 1'b0;

    // Count round to 7 again with the flag set, then reset between edges.
    bus_a.max_val = 8'd9;
    for (int k = 0; k < 10; k++) step();
    check("rst.pre_q", 32'(bus_a.q), 32'd7);
    check("rst.pre_flag", 32'(bus_a.tc_flag), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst.async_q", 32'(bus_a.q), 32'd0);
    check("rst.async_flag", 32'(bus_a.tc_flag), 32'd0);
    model_reset();
    #1 reset = 1'b0;
    step();
    check("rst.first_count", 32'(bus_a.q), 32'd1);

    // Terminal event coinciding with clr_flag keeps the flag.
    bus_a.load = 1'b1; bus_a.d = 8'd9;
    step();
    bus_a.load = 1'b0; bus_a.clr_flag = 1'b1;
    step();
    check("clr_vs_term.q", 32'(bus_a.q), 32'd0);
    check("clr_vs_term.flag", 32'(bus_a.tc_flag), 32'd1);
    bus_a.clr_flag = 1'b0;

    // Zero modulus: stuck at 0, terminal every enabled cycle in both directions.
    bus_a.max_val = 8'd0;
    step();
    check("mv0.up_pulse", 32'(bus_a.tc_pulse), 32'd1);
    check("mv0.up_mm", 32'(bus_a.max_min), 32'd1);
    bus_a.up_down = 1'b1;
    step();
    check("mv0.dn_q", 32'(bus_a.q), 32'd0);
    check("mv0.dn_mm", 32'(bus_a.max_min), 32'd1);

    // Limit lowered below q: down snaps without an event, up wraps with one.
    bus_a.max_val = 8'd9; bus_a.load = 1'b1; bus_a.d = 8'd8;
    step();
    bus_a.load = 1'b0; bus_a.max_val = 8'd3;
    step();
    check("lower.dn_q", 32'(bus_a.q), 32'd3);
    check("lower.dn_pulse", 32'(bus_a.tc_pulse), 32'd0);
    bus_a.max_val = 8'd9; bus_a.load = 1'b1;
    step();
    bus_a.load = 1'b0; bus_a.max_val = 8'd3; bus_a.up_down = 1'b0;
    step();
    check("lower.up_q", 32'(bus_a.q), 32'd0);
    check("lower.up_pulse", 32'(bus_a.tc_pulse), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
